// File: rtl/stream_prefetcher_pkg.sv
// Shared types for the sequential-stream instruction prefetcher.
// Fetch FSM encoding, default geometry, index/count widths.
package stream_prefetcher_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } fetch_state_t;

  localparam int NUM_STREAMS_DEF = 4;
  localparam int DEPTH_DEF       = 8;
  localparam int BURST_DEF       = 4;
  localparam int ADDR_W_DEF      = 26;
  localparam int ARID_VAL_DEF    = 2;

  // Width of an index into n entries; never zero.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SIDX_W = idx_w(NUM_STREAMS_DEF);
  localparam int CNT_W  = $clog2(DEPTH_DEF) + 1;

  typedef logic [SIDX_W-1:0] sidx_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/stream_fifo.sv
// One prefetch stream: circular word FIFO, fill count and head address.
// Ports: clear (+clear_addr) restarts it, push appends, pop drops the head.
module stream_fifo
  import stream_prefetcher_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [ADDR_W-1:0] clear_addr,
  input  logic              push,
  input  logic [31:0]       push_data,
  input  logic              pop,
  output logic [CW-1:0]     count,
  output logic [ADDR_W-1:0] head_addr,
  output logic [31:0]       head_data
);

  localparam int PW = idx_w(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rd;
  logic [PW-1:0] wr;

  assign head_data = mem[rd];

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd        <= '0;
      wr        <= '0;
      count     <= '0;
      head_addr <= '0;
    end else if (clear) begin
      rd        <= '0;
      wr        <= '0;
      count     <= '0;
      head_addr <= clear_addr;
    end else begin
      if (push) begin
        wr <= (wr == LAST) ? '0 : wr + 1'b1;
      end
      if (pop) begin
        rd        <= (rd == LAST) ? '0 : rd + 1'b1;
        head_addr <= head_addr + ADDR_W'(4);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/stream_prefetcher.sv
// Multi-stream sequential prefetcher serving I-cache misses from FIFOs.
// Ports: lookup (req_*, hit*), flush, single-outstanding AXI read master.
module stream_prefetcher
  import stream_prefetcher_pkg::*;
#(
  parameter int NUM_STREAMS = NUM_STREAMS_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int BURST       = BURST_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int ARID_VAL    = ARID_VAL_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              hit,
  output logic [31:0]       hit_data,
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [3:0]        ARID,
  output logic [3:0]        ARLEN,
  output logic [ADDR_W-1:0] ARADDR,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic              RLAST,
  input  logic [3:0]        RID,
  input  logic [31:0]       RDATA
);

  localparam int SW = idx_w(NUM_STREAMS);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = ADDR_W;
  localparam logic [SW-1:0] SLAST = SW'(NUM_STREAMS - 1);

  fetch_state_t state;

  logic [NUM_STREAMS-1:0] valid;
  logic [AW-1:0] fetch_addr [NUM_STREAMS];
  logic [CW-1:0] count      [NUM_STREAMS];
  logic [AW-1:0] head_addr  [NUM_STREAMS];
  logic [31:0]   head_data  [NUM_STREAMS];

  logic [SW-1:0] rr_alloc;
  logic [SW-1:0] rr_issue;
  logic [SW-1:0] cur;
  logic [SW-1:0] win;
  logic [SW-1:0] pick;
  logic          pick_ok;
  logic          drop;
  logic          alloc;
  logic          beat_ok;
  logic          last;
  logic          push_en;
  logic [AW-1:0] new_addr;

  assign ARVALID  = (state == ADDR);
  assign RREADY   = (state == DATA);
  assign ARID     = 4'(ARID_VAL);
  assign ARLEN    = 4'(BURST - 1);
  assign new_addr = {req_addr[AW-1:2], 2'b00};

  // Descending scan so the lowest matching index ends up in win.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (valid[i] && count[i] != '0 &&
          head_addr[i][AW-1:2] == req_addr[AW-1:2]) begin
        hit = 1'b1;
        win = SW'(i);
      end
    end
    hit = hit && req_valid && !flush;
  end

  assign hit_data = hit ? head_data[win] : 32'h0;
  assign alloc    = req_valid && !hit && !flush;

  assign beat_ok = RVALID && RREADY &&
                   RID == 4'(ARID_VAL);
  assign last    = beat_ok && RLAST;
  assign push_en = beat_ok && !drop && !flush &&
                   !(alloc && rr_alloc == cur);

  // A stream being allocated this edge is skipped: its fetch
  // address is about to be replaced.
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    for (int k = 1; k <= NUM_STREAMS; k++) begin
      int idx;
      idx = (int'(rr_issue) + k) % NUM_STREAMS;
      if (!pick_ok && valid[idx] &&
          int'(count[idx]) <= DEPTH - BURST &&
          !(alloc && rr_alloc == SW'(idx))) begin
        pick_ok = 1'b1;
        pick    = SW'(idx);
      end
    end
    pick_ok = pick_ok && state == IDLE && !flush;
  end

  for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_str
    stream_fifo #(
      .DEPTH (DEPTH),
      .ADDR_W(AW)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (flush || (alloc && rr_alloc == SW'(g))),
      .clear_addr(new_addr),
      .push      (push_en && cur == SW'(g)),
      .push_data (RDATA),
      .pop       (hit && win == SW'(g)),
      .count     (count[g]),
      .head_addr (head_addr[g]),
      .head_data (head_data[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      rr_alloc <= '0;
      for (int i = 0; i < NUM_STREAMS; i++) begin
        fetch_addr[i] <= '0;
      end
    end else begin
      if (flush) begin
        valid <= '0;
      end else if (alloc) begin
        valid[rr_alloc] <= 1'b1;
        rr_alloc <= (rr_alloc == SLAST) ? '0 : rr_alloc + 1'b1;
      end
      for (int i = 0; i < NUM_STREAMS; i++) begin
        if (alloc && rr_alloc == SW'(i)) begin
          fetch_addr[i] <= new_addr;
        end else if (pick_ok && pick == SW'(i)) begin
          fetch_addr[i] <= fetch_addr[i] + AW'(4 * BURST);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur      <= '0;
      rr_issue <= '0;
      ARADDR   <= '0;
      drop     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          drop <= 1'b0;
          if (pick_ok) begin
            state    <= ADDR;
            cur      <= pick;
            rr_issue <= pick;
            ARADDR   <= fetch_addr[pick];
          end
        end
        ADDR: begin
          if (ARREADY) begin
            state <= DATA;
          end
          if (flush || (alloc && rr_alloc == cur)) begin
            drop <= 1'b1;
          end
        end
        DATA: begin
          if (last) begin
            state <= IDLE;
            drop  <= 1'b0;
          end else if (flush || (alloc && rr_alloc == cur)) begin
            drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
